// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared data bus between the CPU MEM stage and a DMA requester.
// CPU has priority, a starvation counter forces DMA in, and peripheral accesses get wait states.
module mem_bus_arbiter #(
    parameter int PERIPH_WAIT = 2,
    parameter int STARVE_MAX  = 3,
    parameter int PERIPH_BIT  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  bus_owner
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CPU_WAIT = 2'd1;
    localparam logic [1:0] DMA_WAIT = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    localparam int WAIT_W    = (PERIPH_WAIT > 1) ? $clog2(PERIPH_WAIT) : 1;
    localparam int WAIT_LOAD = (PERIPH_WAIT > 0) ? PERIPH_WAIT - 1 : 0;
    localparam int STARVE_W  = $clog2(STARVE_MAX + 1);

    logic [1:0]          stateReg, stateNext;
    logic [WAIT_W-1:0]   waitCntReg, waitCntNext;
    logic [STARVE_W-1:0] starveCntReg, starveCntNext;
    logic                ackLastReg;

    logic       cpuReq;
    logic       dmaEligible;
    logic       cpuSlow;
    logic       dmaSlow;
    logic       grantSlow;
    logic       dmaGrant;
    logic [1:0] ownerSel;
    logic       done;
    logic       cpuDone;
    logic       dmaDone;
    logic       ownerWe;

    assign cpuReq = cpu_rd | cpu_wr;
    // The requester needs one cycle after its ack to drop or re-present the request.
    assign dmaEligible = dma_req & ~ackLastReg;

    generate
        if (PERIPH_WAIT > 0) begin : gSlow
            assign cpuSlow = cpu_addr[PERIPH_BIT];
            assign dmaSlow = dma_addr[PERIPH_BIT];
        end else begin : gNoSlow
            assign cpuSlow = 1'b0;
            assign dmaSlow = 1'b0;
        end
    endgenerate

    always_comb begin
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        ownerSel    = OWN_NONE;
        grantSlow   = 1'b0;
        dmaGrant    = 1'b0;
        done        = 1'b0;
        case (stateReg)
            IDLE: begin
                if (dmaEligible && (starveCntReg == STARVE_W'(STARVE_MAX))) begin
                    ownerSel = OWN_DMA;
                end else if (cpuReq) begin
                    ownerSel = OWN_CPU;
                end else if (dmaEligible) begin
                    ownerSel = OWN_DMA;
                end
                dmaGrant = (ownerSel == OWN_DMA);
                if (ownerSel == OWN_CPU) begin
                    grantSlow = cpuSlow;
                end else if (ownerSel == OWN_DMA) begin
                    grantSlow = dmaSlow;
                end
                if (ownerSel != OWN_NONE) begin
                    if (grantSlow) begin
                        stateNext   = (ownerSel == OWN_CPU) ? CPU_WAIT : DMA_WAIT;
                        waitCntNext = WAIT_W'(WAIT_LOAD);
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            CPU_WAIT, DMA_WAIT: begin
                ownerSel = (stateReg == CPU_WAIT) ? OWN_CPU : OWN_DMA;
                if (waitCntReg == '0) begin
                    done      = 1'b1;
                    stateNext = IDLE;
                end else begin
                    waitCntNext = waitCntReg - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign cpuDone = done & (ownerSel == OWN_CPU);
    assign dmaDone = done & (ownerSel == OWN_DMA);

    always_comb begin
        starveCntNext = starveCntReg;
        if (dmaGrant || !dma_req) begin
            starveCntNext = '0;
        end else if (cpuDone && (starveCntReg != STARVE_W'(STARVE_MAX))) begin
            starveCntNext = starveCntReg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg     <= IDLE;
            waitCntReg   <= '0;
            starveCntReg <= '0;
            ackLastReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            waitCntReg   <= waitCntNext;
            starveCntReg <= starveCntNext;
            ackLastReg   <= dmaDone;
        end
    end

    always_comb begin
        ownerWe = 1'b0;
        if (ownerSel == OWN_CPU) begin
            ownerWe = cpu_wr;
        end else if (ownerSel == OWN_DMA) begin
            ownerWe = dma_we;
        end
    end

    // Every output is forced idle while reset is held low, even mid-access.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_owner = OWN_NONE;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        dma_ack   = 1'b0;
        dma_rdata = '0;
        if (reset) begin
            mem_en    = (ownerSel != OWN_NONE);
            mem_we    = done & ownerWe;
            bus_owner = ownerSel;
            cpu_stall = cpuReq & ~cpuDone;
            dma_ack   = dmaDone;
            if (ownerSel == OWN_CPU) begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end else if (ownerSel == OWN_DMA) begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            if (cpuDone) begin
                cpu_rdata = mem_rdata;
            end
            if (dmaDone) begin
                dma_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a countdown-based reference model.
module tb_mem_bus_arbiter;

    localparam int PW = 2;
    localparam int SM = 3;
    localparam int PB = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  bus_owner;

    mem_bus_arbiter #(.PERIPH_WAIT(PW), .STARVE_MAX(SM), .PERIPH_BIT(PB)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .bus_owner(bus_owner)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Reference model: the access in flight is an owner plus cycles still to go.
    int mOwner = 0;
    int mRemain = 0;
    int mStarve = 0;
    bit mAckLast = 0;
    int curOwner = 0;
    int curRemain = 0;
    bit curDone = 0;

    bit cpuPending = 0;
    bit dmaPending = 0;

    function automatic int latency(logic [31:0] a);
        return (PW > 0 && a[PB]) ? 1 + PW : 1;
    endfunction

    task automatic check1(string tag, logic [31:0] got, logic [31:0] exp);
        nVec++;
        assert (got === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic settle();
        int own;
        int rem;
        bit dn;
        bit dmaOk;
        logic [31:0] eAddr, eWd, eCpuR, eDmaR;
        bit eWe;
        #1;
        own = 0;
        rem = 0;
        dn = 0;
        if (!reset) begin
            mOwner = 0; mRemain = 0; mStarve = 0; mAckLast = 0;
        end else begin
            own = mOwner;
            rem = mRemain;
            if (rem == 0) begin
                dmaOk = dma_req && !mAckLast;
                if (dmaOk && mStarve == SM) own = 2;
                else if (cpu_rd || cpu_wr) own = 1;
                else if (dmaOk) own = 2;
                else own = 0;
                if (own == 1) rem = latency(cpu_addr);
                else if (own == 2) rem = latency(dma_addr);
            end
            dn = (own != 0) && (rem == 1);
        end
        curOwner = own; curRemain = rem; curDone = dn;
        eAddr = (own == 1) ? cpu_addr : (own == 2) ? dma_addr : 32'h0;
        eWd   = (own == 1) ? cpu_wdata : (own == 2) ? dma_wdata : 32'h0;
        eWe   = dn && ((own == 1) ? cpu_wr : (own == 2) ? dma_we : 1'b0);
        eCpuR = (dn && own == 1) ? mem_rdata : 32'h0;
        eDmaR = (dn && own == 2) ? mem_rdata : 32'h0;
        check1("mem_en", mem_en, 32'(own != 0));
        check1("mem_we", mem_we, 32'(eWe));
        check1("mem_addr", mem_addr, eAddr);
        check1("mem_wdata", mem_wdata, eWd);
        check1("bus_owner", bus_owner, own);
        check1("cpu_stall", cpu_stall, 32'(reset && (cpu_rd || cpu_wr) && !(dn && own == 1)));
        check1("cpu_rdata", cpu_rdata, eCpuR);
        check1("dma_ack", dma_ack, 32'(dn && own == 2));
        check1("dma_rdata", dma_rdata, eDmaR);
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            if (curOwner == 2 || !dma_req) mStarve = 0;
            else if (curDone && curOwner == 1 && mStarve < SM) mStarve++;
            mAckLast = curDone && (curOwner == 2);
            if (curDone || curOwner == 0) begin
                mOwner = 0; mRemain = 0;
            end else begin
                mOwner = curOwner; mRemain = curRemain - 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80; dma_wdata = 32'h0; mem_rdata = 32'h0;
        @(negedge clk);

        // Reset held with both requesters active
        for (int i = 0; i < 2; i++) begin
            settle();
            check1("rst_mem_en", mem_en, 0);
            check1("rst_cpu_stall", cpu_stall, 0);
            check1("rst_dma_ack", dma_ack, 0);
            check1("rst_bus_owner", bus_owner, 0);
            advance();
        end
        reset = 1'b1;
        settle();
        check1("first_grant_cpu", bus_owner, 1);
        advance();

        // CPU RAM load
        dma_req = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        settle();
        check1("ram_load_rdata", cpu_rdata, 32'hDEADBEEF);
        check1("ram_load_stall", cpu_stall, 0);
        check1("ram_load_en", mem_en, 1);
        check1("ram_load_we", mem_we, 0);
        check1("ram_load_owner", bus_owner, 1);
        advance();

        // CPU peripheral store: two wait states, single strobe
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h40000004; cpu_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 3; c++) begin
            settle();
            check1("per_store_stall", cpu_stall, (c < 2) ? 1 : 0);
            check1("per_store_we", mem_we, (c == 2) ? 1 : 0);
            if (c == 2) check1("per_store_wdata", mem_wdata, 32'hCAFEF00D);
            advance();
        end

        // Contention: starvation forces DMA in on the fourth cycle
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h20;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) dma_req = 1'b0;
            mem_rdata = $urandom;
            settle();
            check1("starve_owner", bus_owner, (c == 4) ? 2 : 1);
            check1("starve_ack", dma_ack, (c == 4) ? 1 : 0);
            check1("starve_stall", cpu_stall, (c == 4) ? 1 : 0);
            advance();
        end

        // DMA slow read with a CPU request arriving mid-access
        cpu_rd = 1'b0; dma_req = 1'b1; dma_addr = 32'h40000000; dma_we = 1'b0;
        mem_rdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin cpu_rd = 1'b1; cpu_addr = 32'h30; end
            if (c == 4) dma_req = 1'b0;
            settle();
            check1("dslow_owner", bus_owner, (c == 4) ? 1 : 2);
            check1("dslow_ack", dma_ack, (c == 3) ? 1 : 0);
            if (c >= 2) check1("dslow_stall", cpu_stall, (c == 4) ? 0 : 1);
            if (c == 3) check1("dslow_rdata", dma_rdata, 32'h12345678);
            advance();
        end

        // Reset pulse during a CPU peripheral write aborts it; retry takes full latency
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 32'h40000008; cpu_wdata = 32'h55AA55AA;
        for (int c = 0; c < 2; c++) begin
            settle();
            check1("abort_pre_stall", cpu_stall, 1);
            check1("abort_pre_we", mem_we, 0);
            advance();
        end
        reset = 1'b0;
        settle();
        check1("abort_en", mem_en, 0);
        check1("abort_we", mem_we, 0);
        check1("abort_stall", cpu_stall, 0);
        advance();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check1("retry_stall", cpu_stall, (c < 2) ? 1 : 0);
            check1("retry_we", mem_we, (c == 2) ? 1 : 0);
            advance();
        end
        cpu_wr = 1'b0;

        // Randomized traffic obeying the hold-until-done protocol on both sides
        for (int n = 0; n < 2000; n++) begin
            if (!cpuPending) begin
                r = $urandom;
                cpu_rd = ($urandom_range(0, 9) < 4);
                cpu_wr = ($urandom_range(0, 9) < 3);
                cpu_addr = {r[31], 1'($urandom_range(0, 1)), r[29:2], 2'b00};
                cpu_wdata = $urandom;
                cpuPending = cpu_rd | cpu_wr;
            end
            if (!dmaPending) begin
                r = $urandom;
                dma_req = ($urandom_range(0, 9) < 4);
                dma_we = $urandom_range(0, 1);
                dma_addr = {r[31], 1'($urandom_range(0, 1)), r[29:2], 2'b00};
                dma_wdata = $urandom;
                dmaPending = dma_req;
            end
            reset = ($urandom_range(0, 199) != 0);
            mem_rdata = $urandom;
            settle();
            if (curDone && curOwner == 1) cpuPending = 0;
            if (curDone && curOwner == 2) dmaPending = 0;
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
